fighter_hp_ctrl: RTL
====================

FIGHTER_HP_CTRL -- requirements
Module: fighter_hp_ctrl

Interface
REQ-001 The module SHALL have parameter HP_MAX, default 8'd100, meaning starting and restart health.
REQ-002 The module SHALL have parameter DMG_HIT, default 8'd10, meaning damage from an unblocked hit.
REQ-003 The module SHALL have parameter DMG_BLOCK, default 8'd2, meaning damage from a hit taken while defending.
REQ-004 The module SHALL have parameter HIT_COOLDOWN, default 8'd12, meaning the number of frames after a hit during which further hits are ignored.
REQ-005 The module SHALL have parameter PLAY_STATE, default 8'd1, meaning the game_state value for active play.
REQ-006 The module SHALL have port Clk, input, 1 bit: the single system clock.
REQ-007 The module SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port frame_clk, input, 1 bit: the vertical-sync frame tick; only its rising edge is used.
REQ-009 The module SHALL have port game_state, input, 8 bits: the global game phase.
REQ-010 The module SHALL have inputs key_left, key_right, key_attack and key_defend, 1 bit each: level-held player keys.
REQ-011 The module SHALL have port opp_hit, input, 1 bit: a level from collision logic meaning the opponent's attack box overlaps this fighter.
REQ-012 The module SHALL have outputs character1_move_l, character1_move_r, character1_attack, character1_defend, character1_hurt and character1_die, 1 bit each: requests to the character animation FSM.
REQ-013 The module SHALL have port hp, output, 8 bits: current health, for the health-bar renderer.

Function
REQ-014 The block SHALL detect frame edges with a registered detector: a 1-Clk pulse fe is raised one cycle after frame_clk is seen 1 having been 0 on the previous cycle.
REQ-015 The block SHALL detect a restart edge as a 1-Clk pulse, raised when (game_state==PLAY_STATE) becomes true, using the same registered scheme.
REQ-016 The block SHALL implement states ST_IDLE, ST_ALIVE and ST_DEAD.
- ST_IDLE -> ST_ALIVE on restart edge.
- ST_ALIVE -> ST_DEAD when hp becomes 0.
- ST_ALIVE or ST_DEAD -> ST_IDLE on an fe where game_state!=PLAY_STATE.
- A restart edge from any state -> ST_ALIVE.
REQ-017 On a restart edge, the block SHALL load hp=HP_MAX, clear cooldown, clear all request outputs and clear the attack-key history, taking priority over every other event in that cycle.
REQ-018 All request outputs, hp and cooldown SHALL update only in cycles where fe=1, and SHALL hold their values otherwise.
REQ-019 In ST_ALIVE at fe: character1_move_l SHALL equal key_left&~key_right.
REQ-020 In ST_ALIVE at fe: character1_move_r SHALL equal key_right&~key_left, so that both keys pressed gives no move.
REQ-021 In ST_ALIVE at fe: character1_defend SHALL equal key_defend.
REQ-022 In ST_ALIVE at fe: character1_attack SHALL be 1 only if key_attack=1 and the key_attack value sampled at the previous fe was 0, giving one frame per press.
REQ-023 In ST_ALIVE at fe: a hit SHALL be accepted when opp_hit=1 and cooldown==0.
- Damage = DMG_BLOCK if key_defend=1, else DMG_HIT.
- hp SHALL take hp-damage, saturating at 0 (no wrap).
- cooldown SHALL load HIT_COOLDOWN.
REQ-024 character1_hurt SHALL be 1 for exactly one frame (from an accepted unblocked hit to the next fe), and SHALL stay 0 for blocked hits.
REQ-025 When no hit is accepted at fe and cooldown>0, cooldown SHALL decrement by 1, and SHALL never go below 0.
REQ-026 If a hit drives hp to 0, the block SHALL assert character1_die at that same fe and SHALL hold hurt at 0 for that frame.
REQ-027 In ST_DEAD, character1_die SHALL stay 1, all other requests SHALL be 0, and hp SHALL hold at 0 with opp_hit ignored.
REQ-028 In ST_IDLE, all requests SHALL be 0, hp SHALL hold its value, and opp_hit and the keys SHALL be ignored.
REQ-029 Simultaneous attack press and accepted hit SHALL both be output at the same fe.

Reset
REQ-030 While Reset=0, asynchronously: state=ST_IDLE, hp=HP_MAX, cooldown=0, all request outputs=0, and all edge-detector and key history registers=0.
REQ-031 Leaving reset SHALL NOT by itself produce an fe pulse or a restart pulse, so that the first fe occurs only after a frame_clk 0->1 transition is seen.
REQ-032 Reset asserted mid-frame or mid-cooldown SHALL abandon all progress, and no partial hurt pulse SHALL follow release.

Verification
REQ-033 Apply reset, then set game_state 0->1, then run 1 frame -> hp=100, state ST_ALIVE, all requests 0.
REQ-034 Hold key_attack for 5 frames -> character1_attack=1 on the first frame only; releasing and pressing again -> one more 1-frame pulse.
REQ-035 Hold opp_hit for 30 frames with key_defend=0 -> hits at frames 0, 13 and 26, hp 100->90->80->70, and character1_hurt=1 for exactly frames 0, 13 and 26.
REQ-036 Apply opp_hit with key_defend=1 -> hp drops by 2, character1_hurt stays 0, character1_defend=1.
REQ-037 Start from hp=10 and apply an unblocked hit -> hp=0, character1_die=1, hurt=0, state ST_DEAD; then set game_state to 2 and back to 1 -> hp=100, die=0.
REQ-038 Assert key_left and key_right together -> move_l=move_r=0; pulse Reset low during cooldown -> cooldown=0 and hp=100 immediately, with no Clk edge needed.

Source files
------------

// File: rtl/fighter_hp_ctrl.sv
// Player-one health and input controller.
// Turns level-held keys and the opponent's hit overlap into one-frame requests
// for the character animation FSM, and keeps the health value shown on the bar.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | out of play; requests held at 0, hp frozen, keys and hits ignored
// ST_ALIVE | in play; keys and hits processed once per frame
// ST_DEAD  | hp reached 0; die held high until the round leaves play

module fighter_hp_ctrl #(
  parameter logic [7:0] HP_MAX       = 8'd100,
  parameter logic [7:0] DMG_HIT      = 8'd10,
  parameter logic [7:0] DMG_BLOCK    = 8'd2,
  parameter logic [7:0] HIT_COOLDOWN = 8'd12,
  parameter logic [7:0] PLAY_STATE   = 8'd1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] game_state,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       key_defend,
  input  logic       opp_hit,
  output logic       character1_move_l,
  output logic       character1_move_r,
  output logic       character1_attack,
  output logic       character1_defend,
  output logic       character1_hurt,
  output logic       character1_die,
  output logic [7:0] hp
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       armed;
  logic       frame_q, fe;
  logic       play_q, rs;
  logic       play_now;
  logic [7:0] cooldown, cooldown_nxt;
  logic [7:0] hp_nxt;
  logic [7:0] dmg;
  logic       atk_prev, atk_prev_nxt;
  logic       move_l_nxt, move_r_nxt, attack_nxt, defend_nxt, hurt_nxt, die_nxt;

  assign play_now = (game_state == PLAY_STATE);
  assign dmg      = key_defend ? DMG_BLOCK : DMG_HIT;

  // Registered edge detectors; 'armed' swallows the first cycle after reset so
  // levels already high at release are taken as history, not as new edges.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      armed   <= 1'b0;
      frame_q <= 1'b0;
      fe      <= 1'b0;
      play_q  <= 1'b0;
      rs      <= 1'b0;
    end else begin
      armed   <= 1'b1;
      frame_q <= frame_clk;
      fe      <= armed & frame_clk & ~frame_q;
      play_q  <= play_now;
      rs      <= armed & play_now & ~play_q;
    end
  end

  // State, health, cooldown timer and request registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state             <= ST_IDLE;
      hp                <= HP_MAX;
      cooldown          <= 8'd0;
      atk_prev          <= 1'b0;
      character1_move_l <= 1'b0;
      character1_move_r <= 1'b0;
      character1_attack <= 1'b0;
      character1_defend <= 1'b0;
      character1_hurt   <= 1'b0;
      character1_die    <= 1'b0;
    end else begin
      state             <= state_nxt;
      hp                <= hp_nxt;
      cooldown          <= cooldown_nxt;
      atk_prev          <= atk_prev_nxt;
      character1_move_l <= move_l_nxt;
      character1_move_r <= move_r_nxt;
      character1_attack <= attack_nxt;
      character1_defend <= defend_nxt;
      character1_hurt   <= hurt_nxt;
      character1_die    <= die_nxt;
    end
  end

  // Next-state and per-frame request logic; restart outranks the frame tick.
  always_comb begin
    state_nxt    = state;
    hp_nxt       = hp;
    cooldown_nxt = cooldown;
    atk_prev_nxt = atk_prev;
    move_l_nxt   = character1_move_l;
    move_r_nxt   = character1_move_r;
    attack_nxt   = character1_attack;
    defend_nxt   = character1_defend;
    hurt_nxt     = character1_hurt;
    die_nxt      = character1_die;

    if (rs) begin
      state_nxt    = ST_ALIVE;
      hp_nxt       = HP_MAX;
      cooldown_nxt = 8'd0;
      atk_prev_nxt = 1'b0;
      move_l_nxt   = 1'b0;
      move_r_nxt   = 1'b0;
      attack_nxt   = 1'b0;
      defend_nxt   = 1'b0;
      hurt_nxt     = 1'b0;
      die_nxt      = 1'b0;
    end else if (fe) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_ALIVE, ST_DEAD: begin
          move_l_nxt = 1'b0;
          move_r_nxt = 1'b0;
          attack_nxt = 1'b0;
          defend_nxt = 1'b0;
          hurt_nxt   = 1'b0;
          die_nxt    = 1'b0;
          if (!play_now) begin
            state_nxt = ST_IDLE;
          end else if (state == ST_DEAD) begin
            die_nxt = 1'b1;
          end else begin
            move_l_nxt   = key_left & ~key_right;
            move_r_nxt   = key_right & ~key_left;
            defend_nxt   = key_defend;
            attack_nxt   = key_attack & ~atk_prev;
            atk_prev_nxt = key_attack;
            if (opp_hit && (cooldown == 8'd0)) begin
              hp_nxt       = (hp > dmg) ? (hp - dmg) : 8'd0;
              cooldown_nxt = HIT_COOLDOWN;
              if (hp_nxt == 8'd0) begin
                die_nxt   = 1'b1;
                state_nxt = ST_DEAD;
              end else begin
                hurt_nxt = ~key_defend;
              end
            end else if (cooldown != 8'd0) begin
              cooldown_nxt = cooldown - 8'd1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule
